// File: rtl/mips_seq_divider_pkg.sv
// Shared definitions for the sequential MIPS divider: default width, FSM states
// and iteration-counter sizing. Optional feature macro: MIPS_SIGNED_DIV_EN.
package mips_seq_divider_pkg;

    localparam int unsigned DIV_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } div_state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mips_seq_divider_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface mips_seq_divider_if
    import mips_seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEF
);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivByZero;

    modport master (
        output Start, Signed, Dividend, Divisor,
        input  Quotient, Remainder, Busy, Done, DivByZero
    );

    modport slave (
        input  Start, Signed, Dividend, Divisor,
        output Quotient, Remainder, Busy, Done, DivByZero
    );
endinterface

// File: rtl/div_sub_stage.sv
// Combinational trial subtract a - b as a + ~b + 1; carry out high means a >= b.
module div_sub_stage #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         nonneg
);
    logic [W:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        diff   = sum[W-1:0];
        nonneg = sum[W];
    end
endmodule

// File: rtl/mips_seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU (HI = remainder, LO = quotient).
// Signed operation is compiled in only when MIPS_SIGNED_DIV_EN is defined.
module mips_seq_divider
    import mips_seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    mips_seq_divider_if.slave        bus
);
    localparam int unsigned CW = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dzp_q, dzp_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             sa, sb;
    logic [WIDTH:0]   trial_a, trial_b, trial_diff;
    logic             trial_ok;
    logic             unused_diff_msb;

`ifdef MIPS_SIGNED_DIV_EN
    assign sa = bus.Signed & bus.Dividend[WIDTH-1];
    assign sb = bus.Signed & bus.Divisor[WIDTH-1];
`else
    logic unused_signed;
    assign sa            = 1'b0;
    assign sb            = 1'b0;
    assign unused_signed = bus.Signed;
`endif

    // The partial remainder always stays below the divisor, so its top bit is
    // implicit: the WIDTH+1-bit shifted value is {rem, next dividend bit}.
    assign trial_a         = {rem_q, quo_q[WIDTH-1]};
    assign trial_b         = {1'b0, dvs_q};
    assign unused_diff_msb = trial_diff[WIDTH];

    div_sub_stage #(.W(WIDTH + 1)) u_sub (
        .a      (trial_a),
        .b      (trial_b),
        .diff   (trial_diff),
        .nonneg (trial_ok)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dzp_d       = dzp_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dz_d        = dz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_RUN;
                    cnt_d   = CW'(WIDTH);
                    rem_d   = '0;
                    quo_d   = sa ? -bus.Dividend : bus.Dividend;
                    dvs_d   = sb ? -bus.Divisor : bus.Divisor;
                    qneg_d  = sa ^ sb;
                    rneg_d  = sa;
                    dzp_d   = (bus.Divisor == '0);
                    dz_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                rem_d = trial_ok ? trial_diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], trial_ok};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                quotient_d  = qneg_q ? -quo_q : quo_q;
                remainder_d = rneg_q ? -rem_q : rem_q;
                dz_d        = dzp_q;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dzp_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dzp_q       <= dzp_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dz_q        <= dz_d;
        end
    end

    assign bus.Quotient  = quotient_q;
    assign bus.Remainder = remainder_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.DivByZero = dz_q;

endmodule

// File: tb/tb_mips_seq_divider.sv
// Directed + scoreboard bench for mips_seq_divider; expectations follow
// MIPS_SIGNED_DIV_EN when the bench is built with it.
module tb_mips_seq_divider;
    localparam int unsigned W = 32;

`ifdef MIPS_SIGNED_DIV_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    mips_seq_divider_if #(.WIDTH(W)) bus ();
    mips_seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t         sb_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_sb_nonempty(input string tag);
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
        end
    endtask

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        exp_t e;
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.Signed   = sgn;
        bus.Dividend = a;
        bus.Divisor  = b;
        e.q = eq; e.r = er; e.dz = edz;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Walks cycles 1..W+3 after the accepting edge; inject_at != 0 pulses a
    // stray Start during RUN that the DUT must ignore.
    task automatic finish_op(input string tag, input int unsigned inject_at);
        exp_t e;
        for (int unsigned cyc = 1; cyc <= W + 3; cyc++) begin
            @(negedge clk);
            if (cyc <= W + 1)
                check({tag, " busy/done"}, {30'd0, bus.Busy, bus.Done}, 32'd2);
            if (cyc == 5) begin
                check({tag, " hold Q"}, bus.Quotient, last_q);
                check({tag, " hold R"}, bus.Remainder, last_r);
            end
            if (cyc == W + 2) begin
                check({tag, " done cycle"}, {30'd0, bus.Busy, bus.Done}, 32'd1);
                check_sb_nonempty(tag);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check({tag, " Q"}, bus.Quotient, e.q);
                    check({tag, " R"}, bus.Remainder, e.r);
                    check({tag, " DZ"}, {31'd0, bus.DivByZero}, {31'd0, e.dz});
                    last_q = e.q;
                    last_r = e.r;
                end
            end
            if (cyc == W + 3)
                check({tag, " after done"}, {30'd0, bus.Busy, bus.Done}, 32'd0);
            if (inject_at != 0 && cyc == inject_at) begin
                bus.Start    = 1'b1;
                bus.Signed   = 1'b0;
                bus.Dividend = 32'd5;
                bus.Divisor  = 32'd5;
            end
            if (inject_at != 0 && cyc == inject_at + 1)
                bus.Start = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst          = 1'b1;
        bus.Start    = 1'b0;
        bus.Signed   = 1'b0;
        bus.Dividend = '0;
        bus.Divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset Q", bus.Quotient, '0);
        check("reset R", bus.Remainder, '0);
        check("reset busy/done/dz", {29'd0, bus.Busy, bus.Done, bus.DivByZero}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", {31'd0, bus.Busy}, '0);

        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        finish_op("divu_100_7", 0);

        issue(1'b1, 32'hFFFF_FFF9, 32'd2,
              SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, SGN ? 32'hFFFF_FFFF : 32'd1, 1'b0);
        finish_op("div_m7_2", 0);

        issue(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        finish_op("divu_by_zero", 0);

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
              SGN ? 32'h8000_0000 : 32'd0, SGN ? 32'd0 : 32'h8000_0000, 1'b0);
        finish_op("div_overflow", 0);

        issue(1'b1, 32'd7, 32'hFFFF_FFFE,
              SGN ? 32'hFFFF_FFFD : 32'd0, SGN ? 32'd1 : 32'd7, 1'b0);
        finish_op("div_7_m2", 0);

        issue(1'b1, 32'hFFFF_FFF8, 32'd0,
              SGN ? 32'd1 : 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1);
        finish_op("div_m8_by_zero", 0);

        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        finish_op("divu_max_1", 0);

        issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        finish_op("ignored_start", 10);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 32'h0001_0000);
            issue(1'b0, ra, rb, ra / rb, ra % rb, 1'b0);
            finish_op("divu_rand", 0);
        end

        // Reset asserted in cycle 15 of an operation discards the result.
        issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
        repeat (14) @(negedge clk);
        @(negedge clk);
        check("pre-reset busy", {31'd0, bus.Busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-reset Q", bus.Quotient, '0);
        check("mid-reset R", bus.Remainder, '0);
        check("mid-reset busy/done/dz", {29'd0, bus.Busy, bus.Done, bus.DivByZero}, '0);
        check_sb_nonempty("mid-reset discard");
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        last_q = '0;
        last_r = '0;

        issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        finish_op("divu_9_3", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
